// File: rtl/stepper_pulse_gen.sv
// Single-axis STEP/DIR pulse generator on the ext_out_reg write bus.
// Define STEPPER_ENDSTOP_EN to add the synchronised endstop abort used for homing toward min.
module stepper_pulse_gen #(
  parameter logic [5:0]  BASE_ADDR   = 6'h00,
  parameter int unsigned PULSE_WIDTH = 100,
  parameter int unsigned DIR_SETUP   = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] reg_data,
  input  logic [5:0]  reg_addr,
  input  logic        reg_stb,
  output logic        reg_busy,
  input  logic        endstop,
  output logic        step,
  output logic        dir,
  output logic        enable,
  output logic        moving,
  output logic        done_int,
  output logic [31:0] position
);

  localparam logic [31:0] LP_MIN_PERIOD = 32'(2 * PULSE_WIDTH);
  localparam logic [31:0] LP_PW_LAST    = 32'(PULSE_WIDTH - 1);
  localparam logic [31:0] LP_SETUP_LAST = 32'(DIR_SETUP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_en;
  logic        r_dir;
  logic [31:0] r_period;
  logic [31:0] r_steps_left;
  logic [31:0] r_phase;
  logic [31:0] r_position;

  logic [5:0]  w_off;
  logic        w_wr_ctrl;
  logic        w_wr_period;
  logic        w_wr_steps;
  logic        w_abort_wr;
  logic        w_active;
  logic        w_es_hit;
  logic        w_stop;
  logic        w_rise;
  logic [31:0] w_period_clamped;

  // ---------------------------------------------------------------------------
  // Register decode
  // ---------------------------------------------------------------------------
  assign w_off       = reg_addr - BASE_ADDR;
  assign reg_busy    = (w_off <= 6'd2) && (r_state != S_IDLE);
  assign w_wr_ctrl   = reg_stb && (w_off == 6'd0) && !reg_busy;
  assign w_wr_period = reg_stb && (w_off == 6'd1) && !reg_busy;
  assign w_wr_steps  = reg_stb && (w_off == 6'd2) && !reg_busy;
  assign w_abort_wr  = reg_stb && (w_off == 6'd3);

  assign w_period_clamped = (reg_data < LP_MIN_PERIOD) ? LP_MIN_PERIOD : reg_data;

  assign w_active = (r_state == S_SETUP) || (r_state == S_HIGH) || (r_state == S_LOW);

`ifdef STEPPER_ENDSTOP_EN
  logic [1:0] r_es_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_es_sync <= '0;
    end else begin
      r_es_sync <= {r_es_sync[0], endstop};
    end
  end

  // Only the min-side endstop is wired, so it only matters when heading toward min.
  assign w_es_hit = r_es_sync[1] && !r_dir;
`else
  logic w_endstop_unused;

  assign w_endstop_unused = endstop;
  assign w_es_hit         = 1'b0;
`endif

  // A software abort and an endstop trip in the same cycle collapse into one DONE.
  assign w_stop = w_active && (w_abort_wr || w_es_hit);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_wr_steps) begin
          if ((reg_data == '0) || w_es_hit) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        if (r_phase == LP_SETUP_LAST) begin
          w_state_nxt = S_HIGH;
        end
      end
      S_HIGH: begin
        if (r_phase == LP_PW_LAST) begin
          w_state_nxt = S_LOW;
        end
      end
      S_LOW: begin
        if (r_phase == r_period - 32'd1) begin
          w_state_nxt = (r_steps_left != '0) ? S_HIGH : S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_stop) begin
      w_state_nxt = S_DONE;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    step     = 1'b0;
    moving   = 1'b1;
    done_int = 1'b0;
    case (r_state)
      S_IDLE:  moving   = 1'b0;
      S_HIGH:  step     = 1'b1;
      S_DONE:  done_int = 1'b1;
      default: ;
    endcase
  end

  assign dir      = r_dir;
  assign enable   = ~r_en;
  assign position = r_position;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  assign w_rise = (w_state_nxt == S_HIGH) && (r_state != S_HIGH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en   <= 1'b0;
      r_dir  <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_en   <= reg_data[0];
      r_dir  <= reg_data[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= LP_MIN_PERIOD;
    end else if (w_wr_period) begin
      r_period <= w_period_clamped;
    end
  end

  // Phase restarts at each STEP rise and runs on through LOW, so LOW ends at period-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
    end else if (w_rise || !w_active) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_steps_left <= '0;
    end else if (w_wr_steps) begin
      r_steps_left <= reg_data;
    end else if (w_rise) begin
      r_steps_left <= r_steps_left - 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_position <= '0;
    end else if (w_rise) begin
      r_position <= r_dir ? (r_position + 32'd1) : (r_position - 32'd1);
    end
  end

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Self-checking bench for stepper_pulse_gen: vector table, corner sequences and random moves
// compared against a timing/position model built from step latency, period and count.
module tb_stepper_pulse_gen;

  localparam logic [5:0]  BASE = 6'h10;
  localparam int unsigned PW   = 100;
  localparam int unsigned DS   = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] reg_data = '0;
  logic [5:0]  reg_addr = BASE + 6'd4;
  logic        reg_stb = 1'b0;
  logic        reg_busy;
  logic        endstop = 1'b0;
  logic        step, dir, enable, moving, done_int;
  logic [31:0] position;

  stepper_pulse_gen #(
    .BASE_ADDR  (BASE),
    .PULSE_WIDTH(PW),
    .DIR_SETUP  (DS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .reg_data(reg_data),
    .reg_addr(reg_addr),
    .reg_stb (reg_stb),
    .reg_busy(reg_busy),
    .endstop (endstop),
    .step    (step),
    .dir     (dir),
    .enable  (enable),
    .moving  (moving),
    .done_int(done_int),
    .position(position)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        prev_step = 1'b0;
  int          rises[$];
  int          falls[$];
  int          dones[$];
  logic [31:0] m_pos = '0;
  int unsigned m_period = 2 * PW;

  typedef struct {
    logic [31:0] ctrl;
    logic [31:0] period;
    logic [31:0] steps;
    logic        exp_enable;
    logic        exp_dir;
    logic [31:0] exp_pos;
    int unsigned exp_eff;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (step && !prev_step) rises.push_back(cyc);
    if (!step && prev_step) falls.push_back(cyc);
    if (done_int) dones.push_back(cyc);
    prev_step = step;
  endtask

  task automatic clear_mon();
    rises.delete();
    falls.delete();
    dones.delete();
  endtask

  task automatic wr(input int unsigned off, input logic [31:0] d, output int c);
    reg_addr = BASE + 6'(off);
    reg_data = d;
    reg_stb  = 1'b1;
    tick();
    c        = cyc;
    reg_stb  = 1'b0;
    reg_addr = BASE + 6'd4;
  endtask

  function automatic int unsigned eff_period(input int unsigned p);
    return (p < 2 * PW) ? 2 * PW : p;
  endfunction

  // Expected timeline: first rise DS+1 after the strobe, rises every eff clocks,
  // done one period after the last rise (or right after the strobe for zero steps).
  task automatic run_move(input string tag, input int unsigned n, input int unsigned eff,
                          input logic d);
    int c0, exp_done, limit, d0;
    clear_mon();
    wr(2, n, c0);
    exp_done = (n == 0) ? c0 : c0 + int'(DS) + 1 + int'(n * eff);
    limit    = exp_done + 20;
    while (cyc < limit) tick();
    if (d) m_pos = m_pos + n;
    else   m_pos = m_pos - n;
    chk({tag, ".rises"}, rises.size(), n);
    for (int k = 0; k < rises.size() && k < int'(n); k++) begin
      chk({tag, ".rise_t"}, rises[k], c0 + int'(DS) + 1 + k * int'(eff));
      if (k < falls.size()) chk({tag, ".width"}, falls[k] - rises[k], PW);
      else                  chk({tag, ".width_missing"}, 0, PW);
    end
    d0 = (dones.size() > 0) ? dones[0] : -1;
    chk({tag, ".done_cnt"}, dones.size(), 1);
    chk({tag, ".done_t"}, d0, exp_done);
    chk({tag, ".pos"}, position, m_pos);
    chk({tag, ".moving"}, moving, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c0, t, d0;
    int unsigned n, p, eff;
    logic d;

    vecs[0] = '{32'd3, 32'd1000, 32'd5, 1'b0, 1'b1, 32'd5,          1000};
    vecs[1] = '{32'd1, 32'd10,   32'd3, 1'b0, 1'b0, 32'd2,          200};
    vecs[2] = '{32'd3, 32'd0,    32'd0, 1'b0, 1'b1, 32'd2,          200};
    vecs[3] = '{32'd2, 32'd201,  32'd2, 1'b1, 1'b1, 32'd4,          201};
    vecs[4] = '{32'd0, 32'd200,  32'd4, 1'b1, 1'b0, 32'd0,          200};
    vecs[5] = '{32'd1, 32'd199,  32'd1, 1'b0, 1'b0, 32'hFFFF_FFFF, 200};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst.step", step, 1'b0);
    chk("rst.dir", dir, 1'b0);
    chk("rst.enable", enable, 1'b1);
    chk("rst.moving", moving, 1'b0);
    chk("rst.done", done_int, 1'b0);
    chk("rst.pos", position, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Vector table
    for (int i = 0; i < 6; i++) begin
      wr(0, vecs[i].ctrl, c0);
      chk("vec.enable", enable, vecs[i].exp_enable);
      chk("vec.dir", dir, vecs[i].exp_dir);
      wr(1, vecs[i].period, c0);
      m_period = vecs[i].period;
      run_move($sformatf("vec%0d", i), vecs[i].steps, vecs[i].exp_eff, vecs[i].exp_dir);
      chk("vec.pos_table", position, vecs[i].exp_pos);
    end

    // Busy blocks PERIOD/CTRL writes mid-move; ABORT address is never busy
    wr(0, 3, c0);
    wr(1, 200, c0);
    m_period = 200;
    clear_mon();
    wr(2, 4, c0);
    tick();
    reg_addr = BASE + 6'd1;
    #1 chk("busy.period_addr", reg_busy, 1'b1);
    reg_addr = BASE + 6'd3;
    #1 chk("busy.abort_addr", reg_busy, 1'b0);
    wr(1, 5000, t);
    wr(0, 0, t);
    chk("busy.dir_kept", dir, 1'b1);
    chk("busy.enable_kept", enable, 1'b0);
    while (dones.size() == 0 && cyc < c0 + 2000) tick();
    chk("busy.rises", rises.size(), 4);
    if (rises.size() == 4) chk("busy.spacing", rises[3] - rises[0], 600);
    m_pos = m_pos + 4;
    chk("busy.pos", position, m_pos);
    tick();
    reg_addr = BASE + 6'd1;
    #1 chk("busy.idle", reg_busy, 1'b0);
    wr(0, 1, t);
    chk("idle.ctrl_dir", dir, 1'b0);

    // ABORT after the third rise, while STEP is still high
    wr(0, 3, t);
    wr(1, 1000, t);
    m_period = 1000;
    clear_mon();
    wr(2, 100, c0);
    while (rises.size() < 3 && cyc < c0 + 3000) tick();
    chk("abort.rises", rises.size(), 3);
    wr(3, 32'hDEAD, t);
    chk("abort.step", step, 1'b0);
    chk("abort.done", done_int, 1'b1);
    m_pos = m_pos + 3;
    chk("abort.pos", position, m_pos);
    repeat (5) tick();
    chk("abort.done_cnt", dones.size(), 1);
    chk("abort.moving", moving, 1'b0);
    clear_mon();
    wr(3, 0, t);
    repeat (3) tick();
    chk("abort_idle.done_cnt", dones.size(), 0);
    chk("abort_idle.moving", moving, 1'b0);

    // Reset in the middle of a HIGH phase
    clear_mon();
    wr(2, 10, c0);
    while (rises.size() < 1 && cyc < c0 + 200) tick();
    repeat (10) tick();
    chk("rstmid.step_before", step, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid.step", step, 1'b0);
    chk("rstmid.enable", enable, 1'b1);
    chk("rstmid.pos", position, 32'd0);
    chk("rstmid.moving", moving, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rstmid.no_done", dones.size(), 0);
    m_pos = '0;
    m_period = 2 * PW;
    wr(0, 3, t);
    run_move("post_rst", 2, eff_period(m_period), 1'b1);

    // Random moves against the model
    for (int i = 0; i < 8; i++) begin
      d = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        p = $urandom_range(0, 450);
        wr(1, p, t);
        m_period = p;
      end
      wr(0, {30'd0, d, 1'b1}, t);
      n   = $urandom_range(0, 6);
      eff = eff_period(m_period);
      run_move($sformatf("rnd%0d", i), n, eff, d);
    end

`ifdef STEPPER_ENDSTOP_EN
    wr(0, 1, t);
    wr(1, 200, t);
    m_period = 200;
    clear_mon();
    wr(2, 50, c0);
    while (rises.size() < 2 && cyc < c0 + 1000) tick();
    endstop = 1'b1;
    t = cyc;
    while (dones.size() == 0 && cyc < t + 6) tick();
    d0 = (dones.size() > 0) ? dones[0] : -1;
    chk("es.latency", d0 - t, 3);
    chk("es.step", step, 1'b0);
    m_pos = m_pos - rises.size();
    chk("es.pos", position, m_pos);
    repeat (3) tick();
    chk("es.done_cnt", dones.size(), 1);
    clear_mon();
    wr(2, 5, c0);
    repeat (3) tick();
    chk("es_block.rises", rises.size(), 0);
    d0 = (dones.size() > 0) ? dones[0] : -1;
    chk("es_block.done_t", d0, c0);
    wr(0, 3, t);
    run_move("es_dir1", 3, 200, 1'b1);
    endstop = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
